// File: rtl/tuner_sweep_if.sv
// Configuration, command and tuner-drive signals of the tuner sweep controller.
// cmd_start/cmd_stop are single-cycle pulses sampled on posedge clk; outputs change only on posedge clk.
interface tuner_sweep_if #(
    parameter int FSZ = 26,
    parameter int CSZ = 16
);
    logic [FSZ-1:0] cfg_start;
    logic [FSZ-1:0] cfg_step;
    logic [CSZ-1:0] cfg_points;
    logic [CSZ-1:0] cfg_dwell;
    logic [1:0]     cfg_mode;
    logic           cfg_ns_en;
    logic           cmd_start;
    logic           cmd_stop;
    logic [FSZ-1:0] lo_freq;
    logic           lo_ns_en;
    logic           busy;
    logic           settled;
    logic           step_strobe;
    logic           sweep_done;
    logic [1:0]     fsm_state;

    modport master (
        output cfg_start, cfg_step, cfg_points, cfg_dwell, cfg_mode, cfg_ns_en,
        output cmd_start, cmd_stop,
        input  lo_freq, lo_ns_en, busy, settled, step_strobe, sweep_done, fsm_state
    );

    modport slave (
        input  cfg_start, cfg_step, cfg_points, cfg_dwell, cfg_mode, cfg_ns_en,
        input  cmd_start, cmd_stop,
        output lo_freq, lo_ns_en, busy, settled, step_strobe, sweep_done, fsm_state
    );
endinterface

// File: rtl/tuner_sweep_ctrl.sv
// Tuning-word sequencer: static tune, one-shot and continuous stepped sweeps,
// with a settled flag blanked for SETTLE cycles after every retune.
module tuner_sweep_ctrl #(
    parameter int FSZ    = 26,
    parameter int CSZ    = 16,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          reset,
    tuner_sweep_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DWELL  = 2'd2
    } state_t;

    localparam logic [CSZ-1:0] SETTLE_CNT = CSZ'(SETTLE);
    localparam logic [CSZ-1:0] ONE        = CSZ'(1);

    state_t         state;
    logic [FSZ-1:0] sh_start;
    logic [FSZ-1:0] sh_step;
    logic [CSZ-1:0] sh_last;
    logic [CSZ-1:0] sh_dwell;
    logic [1:0]     sh_mode;
    logic [CSZ-1:0] cnt;
    logic [CSZ-1:0] k;
    logic           sweep_mode;

    // Mode 3 is reserved and behaves as static.
    assign sweep_mode    = (sh_mode == 2'd1) || (sh_mode == 2'd2);
    assign bus.fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            sh_start        <= '0;
            sh_step         <= '0;
            sh_last         <= '0;
            sh_dwell        <= '0;
            sh_mode         <= '0;
            cnt             <= '0;
            k               <= '0;
            bus.lo_freq     <= '0;
            bus.lo_ns_en    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.settled     <= 1'b0;
            bus.step_strobe <= 1'b0;
            bus.sweep_done  <= 1'b0;
        end else begin
            bus.step_strobe <= 1'b0;
            bus.sweep_done  <= 1'b0;
            if (state != S_IDLE && bus.cmd_stop) begin
                state       <= S_IDLE;
                bus.busy    <= 1'b0;
                bus.settled <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.cmd_start && !bus.cmd_stop) begin
                            sh_start        <= bus.cfg_start;
                            sh_step         <= bus.cfg_step;
                            sh_last         <= (bus.cfg_points == '0) ? '0 : bus.cfg_points - ONE;
                            sh_dwell        <= (bus.cfg_dwell == '0) ? ONE : bus.cfg_dwell;
                            sh_mode         <= bus.cfg_mode;
                            k               <= '0;
                            cnt             <= SETTLE_CNT;
                            bus.lo_freq     <= bus.cfg_start;
                            bus.lo_ns_en    <= bus.cfg_ns_en;
                            bus.step_strobe <= 1'b1;
                            bus.busy        <= 1'b1;
                            bus.settled     <= 1'b0;
                            state           <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt <= ONE) begin
                            state       <= S_DWELL;
                            bus.settled <= 1'b1;
                            cnt         <= sh_dwell;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    S_DWELL: begin
                        // Static tune parks here until stopped.
                        if (sweep_mode) begin
                            if (cnt > ONE) begin
                                cnt <= cnt - ONE;
                            end else if (k != sh_last) begin
                                k               <= k + ONE;
                                bus.lo_freq     <= bus.lo_freq + sh_step;
                                bus.step_strobe <= 1'b1;
                                bus.settled     <= 1'b0;
                                cnt             <= SETTLE_CNT;
                                state           <= S_SETTLE;
                            end else begin
                                bus.sweep_done <= 1'b1;
                                bus.settled    <= 1'b0;
                                if (sh_mode == 2'd1) begin
                                    bus.busy <= 1'b0;
                                    state    <= S_IDLE;
                                end else begin
                                    k               <= '0;
                                    bus.lo_freq     <= sh_start;
                                    bus.step_strobe <= 1'b1;
                                    cnt             <= SETTLE_CNT;
                                    state           <= S_SETTLE;
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// Directed bench for tuner_sweep_ctrl: reset, static, one-shot, continuous,
// command collisions and configuration latching.
module tb_tuner_sweep_ctrl;
    localparam int FSZ = 26;
    localparam int CSZ = 16;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    tuner_sweep_if #(.FSZ(FSZ), .CSZ(CSZ)) bus ();

    tuner_sweep_ctrl #(.FSZ(FSZ), .CSZ(CSZ), .SETTLE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [FSZ-1:0] start, input logic [FSZ-1:0] step,
                           input int points, input int dwell, input int mode, input logic ns);
        bus.cfg_start  = start;
        bus.cfg_step   = step;
        bus.cfg_points = CSZ'(points);
        bus.cfg_dwell  = CSZ'(dwell);
        bus.cfg_mode   = 2'(mode);
        bus.cfg_ns_en  = ns;
    endtask

    task automatic pulse_start();
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.cmd_stop = 1'b1;
        tick();
        bus.cmd_stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.lo_freq !== '0 || bus.lo_ns_en !== 1'b0 || bus.busy !== 1'b0 || bus.settled !== 1'b0 ||
            bus.step_strobe !== 1'b0 || bus.sweep_done !== 1'b0 || bus.fsm_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_values got lo=%h ns=%b busy=%b set=%b str=%b done=%b st=%0d exp all 0",
                     bus.lo_freq, bus.lo_ns_en, bus.busy, bus.settled, bus.step_strobe, bus.sweep_done, bus.fsm_state);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_static();
        int strobes;
        int unsettled;
        set_cfg(26'h0100000, 26'h0000100, 5, 3, 0, 1'b0);
        pulse_start();
        tests++;
        if (bus.lo_freq !== 26'h0100000 || bus.step_strobe !== 1'b1 || bus.busy !== 1'b1 || bus.settled !== 1'b0) begin
            fails++;
            $display("FAIL static_t1 got lo=%h str=%b busy=%b set=%b exp 0100000 1 1 0",
                     bus.lo_freq, bus.step_strobe, bus.busy, bus.settled);
        end
        unsettled = 0;
        for (int t = 2; t <= 4; t++) begin
            tick();
            if (bus.settled !== 1'b0 || bus.step_strobe !== 1'b0) unsettled++;
        end
        tests++;
        if (unsettled != 0) begin
            fails++;
            $display("FAIL static_settling got %0d bad cycles exp 0", unsettled);
        end
        tick();
        tests++;
        if (bus.settled !== 1'b1) begin
            fails++;
            $display("FAIL static_t5_settled got %b exp 1", bus.settled);
        end
        strobes = 0;
        unsettled = 0;
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (bus.step_strobe === 1'b1 || bus.sweep_done === 1'b1) strobes++;
            if (bus.settled !== 1'b1 || bus.lo_freq !== 26'h0100000) unsettled++;
        end
        tests++;
        if (strobes != 0 || unsettled != 0) begin
            fails++;
            $display("FAIL static_hold got strobes=%0d bad=%0d exp 0 0", strobes, unsettled);
        end
        pulse_stop();
        tests++;
        if (bus.busy !== 1'b0 || bus.settled !== 1'b0 || bus.lo_freq !== 26'h0100000 || bus.sweep_done !== 1'b0) begin
            fails++;
            $display("FAIL static_stop got busy=%b set=%b lo=%h done=%b exp 0 0 0100000 0",
                     bus.busy, bus.settled, bus.lo_freq, bus.sweep_done);
        end
    endtask

    task automatic test_one_shot();
        logic [FSZ-1:0] exp_lo;
        logic           exp_str, exp_done, exp_busy, exp_set;
        int             bad;
        set_cfg(26'h0001000, 26'h0000800, 3, 2, 1, 1'b0);
        pulse_start();
        bad = 0;
        for (int t = 1; t <= 24; t++) begin
            exp_lo   = (t < 7) ? 26'h0001000 : (t < 13) ? 26'h0001800 : 26'h0002000;
            exp_str  = (t == 1 || t == 7 || t == 13);
            exp_done = (t == 19);
            exp_busy = (t < 19);
            exp_set  = (t == 5 || t == 6 || t == 11 || t == 12 || t == 17 || t == 18);
            if (bus.lo_freq !== exp_lo || bus.step_strobe !== exp_str || bus.sweep_done !== exp_done ||
                bus.busy !== exp_busy || bus.settled !== exp_set) begin
                bad++;
                $display("FAIL one_shot t=%0d got lo=%h str=%b done=%b busy=%b set=%b exp %h %b %b %b %b",
                         t, bus.lo_freq, bus.step_strobe, bus.sweep_done, bus.busy, bus.settled,
                         exp_lo, exp_str, exp_done, exp_busy, exp_set);
            end
            tick();
        end
        tests++;
        if (bad != 0) fails++;
        tests++;
        if (bus.fsm_state !== 2'd0 || bus.lo_freq !== 26'h0002000) begin
            fails++;
            $display("FAIL one_shot_idle got st=%0d lo=%h exp 0 0002000", bus.fsm_state, bus.lo_freq);
        end
    endtask

    task automatic test_continuous();
        logic [FSZ-1:0] exp_lo;
        logic           exp_str, exp_done, exp_set;
        int             bad;
        set_cfg(26'h0000010, 26'h3FFFFE0, 2, 0, 2, 1'b0);
        pulse_start();
        bad = 0;
        for (int t = 1; t <= 40; t++) begin
            exp_lo   = (((t - 1) / 5) % 2 == 1) ? 26'h3FFFFF0 : 26'h0000010;
            exp_str  = ((t - 1) % 5 == 0);
            exp_done = (t > 1) && ((t - 1) % 10 == 0);
            exp_set  = ((t - 1) % 5 == 4);
            if (bus.lo_freq !== exp_lo || bus.step_strobe !== exp_str || bus.sweep_done !== exp_done ||
                bus.busy !== 1'b1 || bus.settled !== exp_set) begin
                bad++;
                $display("FAIL continuous t=%0d got lo=%h str=%b done=%b busy=%b set=%b exp %h %b %b 1 %b",
                         t, bus.lo_freq, bus.step_strobe, bus.sweep_done, bus.busy, bus.settled,
                         exp_lo, exp_str, exp_done, exp_set);
            end
            tick();
        end
        tests++;
        if (bad != 0) fails++;
        pulse_stop();
        tests++;
        if (bus.busy !== 1'b0 || bus.sweep_done !== 1'b0) begin
            fails++;
            $display("FAIL continuous_stop got busy=%b done=%b exp 0 0", bus.busy, bus.sweep_done);
        end
    endtask

    task automatic test_reset_mid_sweep();
        set_cfg(26'h0000010, 26'h3FFFFE0, 2, 3, 2, 1'b1);
        pulse_start();
        for (int t = 1; t < 6; t++) tick();
        tests++;
        if (bus.settled !== 1'b1 || bus.fsm_state !== 2'd2) begin
            fails++;
            $display("FAIL reset_mid_pre got set=%b st=%0d exp 1 2", bus.settled, bus.fsm_state);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (bus.lo_freq !== '0 || bus.lo_ns_en !== 1'b0 || bus.busy !== 1'b0 || bus.settled !== 1'b0 ||
            bus.step_strobe !== 1'b0 || bus.sweep_done !== 1'b0 || bus.fsm_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid got lo=%h ns=%b busy=%b set=%b str=%b done=%b exp all 0",
                     bus.lo_freq, bus.lo_ns_en, bus.busy, bus.settled, bus.step_strobe, bus.sweep_done);
        end
        tick();
        pulse_start();
        tests++;
        if (bus.lo_freq !== 26'h0000010 || bus.step_strobe !== 1'b1 || bus.lo_ns_en !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_restart got lo=%h str=%b ns=%b busy=%b exp 0000010 1 1 1",
                     bus.lo_freq, bus.step_strobe, bus.lo_ns_en, bus.busy);
        end
        pulse_stop();
    endtask

    task automatic test_collisions();
        int bad;
        set_cfg(26'h0000500, 26'h0000100, 4, 1, 1, 1'b0);
        bus.cmd_start = 1'b1;
        bus.cmd_stop  = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.step_strobe !== 1'b0 || bus.fsm_state !== 2'd0) begin
            fails++;
            $display("FAIL start_stop_idle got busy=%b str=%b st=%0d exp 0 0 0", bus.busy, bus.step_strobe, bus.fsm_state);
        end
        pulse_start();
        set_cfg(26'h0000999, 26'h0000300, 4, 1, 1, 1'b1);
        pulse_start();
        tests++;
        if (bus.step_strobe !== 1'b0 || bus.lo_freq !== 26'h0000500 || bus.lo_ns_en !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL start_while_busy got str=%b lo=%h ns=%b busy=%b exp 0 0000500 0 1",
                     bus.step_strobe, bus.lo_freq, bus.lo_ns_en, bus.busy);
        end
        pulse_stop();
        bad = 0;
        for (int t = 0; t < 12; t++) begin
            if (bus.settled !== 1'b0 || bus.busy !== 1'b0 || bus.step_strobe !== 1'b0 || bus.sweep_done !== 1'b0) bad++;
            tick();
        end
        tests++;
        if (bad != 0 || bus.lo_freq !== 26'h0000500) begin
            fails++;
            $display("FAIL stop_in_settle got bad=%0d lo=%h exp 0 0000500", bad, bus.lo_freq);
        end
    endtask

    task automatic test_ns_latch();
        int bad;
        set_cfg(26'h0002000, 26'h0000010, 4, 1, 2, 1'b1);
        pulse_start();
        tests++;
        if (bus.lo_ns_en !== 1'b1 || bus.lo_freq !== 26'h0002000) begin
            fails++;
            $display("FAIL ns_start got ns=%b lo=%h exp 1 0002000", bus.lo_ns_en, bus.lo_freq);
        end
        tick();
        set_cfg(26'h0003333, 26'h0000777, 2, 9, 0, 1'b0);
        bad = 0;
        for (int t = 2; t <= 21; t++) begin
            if (t == 6 && (bus.lo_freq !== 26'h0002010 || bus.step_strobe !== 1'b1)) bad++;
            if (t == 11 && (bus.lo_freq !== 26'h0002020 || bus.step_strobe !== 1'b1)) bad++;
            if (t == 16 && (bus.lo_freq !== 26'h0002030 || bus.step_strobe !== 1'b1)) bad++;
            if (t == 21 && (bus.lo_freq !== 26'h0002000 || bus.step_strobe !== 1'b1 || bus.sweep_done !== 1'b1)) bad++;
            if (bus.lo_ns_en !== 1'b1) bad++;
            if (bad != 0) begin
                $display("FAIL ns_latch t=%0d got lo=%h str=%b done=%b ns=%b", t, bus.lo_freq,
                         bus.step_strobe, bus.sweep_done, bus.lo_ns_en);
                break;
            end
            tick();
        end
        tests++;
        if (bad != 0) fails++;
        pulse_stop();
        tests++;
        if (bus.lo_ns_en !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL ns_hold_after_stop got ns=%b busy=%b exp 1 0", bus.lo_ns_en, bus.busy);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b1;
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        set_cfg('0, '0, 0, 0, 0, 1'b0);
        test_reset();
        test_static();
        test_one_shot();
        test_continuous();
        test_reset_mid_sweep();
        test_collisions();
        test_ns_latch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
